// File: rtl/openhw_stage_tracker_pkg.sv
// ---------------------------------------------------------------------------
// openhw_stage_tracker_pkg
// Purpose : Shared definitions for the pipeline stage tracker and its
//           performance counters.
// Contents: CNTW_DEFAULT - default counter width
//           cnt_sel_e    - CSR write-port counter select encoding
// ---------------------------------------------------------------------------
package openhw_stage_tracker_pkg;

  // Default width of every performance counter.
  localparam int CNTW_DEFAULT = 64;

  // Counter select used by the CSR write port. Encoding 3 is reserved:
  // a write that selects it changes no counter.
  typedef enum logic [1:0] {
    CNT_CYCLE   = 2'd0,
    CNT_RETIRED = 2'd1,
    CNT_BUBBLE  = 2'd2,
    CNT_NONE    = 2'd3
  } cnt_sel_e;

endpackage

// File: rtl/openhw_flopenrc.sv
// ---------------------------------------------------------------------------
// openhw_flopenrc
// Purpose : Register with enable and synchronous clear.
// Ports   : clk   - clock, rising edge
//           reset - synchronous active-high reset, forces q to 0
//           clear - synchronous clear, wins over enable
//           en    - load d when set, otherwise hold
//           d     - next value
//           q     - registered value
// ---------------------------------------------------------------------------
module openhw_flopenrc #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] value_q;

  // Reset and clear both empty the register; clear is checked ahead of the
  // enable so that a flush always beats a stall in the caller.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else if (clear) begin
      value_q <= '0;
    end else if (en) begin
      value_q <= d;
    end
  end

  assign q = value_q;

endmodule

// File: rtl/openhw_perfcnt.sv
// ---------------------------------------------------------------------------
// openhw_perfcnt
// Purpose : One performance counter with inhibit, CSR load and increment.
// Ports   : clk       - clock, rising edge
//           reset     - synchronous active-high reset, counter to 0
//           Inhibit   - freezes the increment (a write still lands)
//           IncEn     - event to count this cycle
//           WriteEn   - load WriteData this cycle (already decoded)
//           WriteData - value to load
//           Count     - registered counter value
// ---------------------------------------------------------------------------
module openhw_perfcnt #(
  parameter int CNTW = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Inhibit,
  input  logic            IncEn,
  input  logic            WriteEn,
  input  logic [CNTW-1:0] WriteData,
  output logic [CNTW-1:0] Count
);

  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;

  // Next-value selection: a CSR write overrides any increment in the same
  // cycle; otherwise the counter advances on an uninhibited event and wraps
  // silently through the natural modulo-2^CNTW addition.
  always_comb begin
    count_d = count_q;
    if (WriteEn) begin
      count_d = WriteData;
    end else if (IncEn && !Inhibit) begin
      count_d = count_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  // Counter storage; reset beats any pending write or increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;

endmodule

// File: rtl/openhw_stage_tracker.sv
// ---------------------------------------------------------------------------
// openhw_stage_tracker
// Purpose : Tracks which of the D/E/M/W pipeline stages hold a live
//           instruction and keeps cycle, retired-instruction and
//           writeback-bubble performance counters.
// Ports   : clk, reset                  - clock and sync active-high reset
//           StallD/E/M/W, FlushD/E/M/W  - hazard unit controls per stage
//           InstrValidF                 - Fetch holds a valid instruction
//           InstrValidD/E/M/W           - stage holds a live instruction
//           InstrRetiredW               - W instruction commits this cycle
//           CntInhibit                  - bit0 cycle, bit1 retired, bit2 bubble
//           CntWriteEn/CntSel/CntWriteData - CSR counter write port
//           CycleCnt/RetiredCnt/BubbleCnt  - counter values
// ---------------------------------------------------------------------------
module openhw_stage_tracker
  import openhw_stage_tracker_pkg::*;
#(
  parameter int CNTW = CNTW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            StallE,
  input  logic            StallM,
  input  logic            StallW,
  input  logic            FlushD,
  input  logic            FlushE,
  input  logic            FlushM,
  input  logic            FlushW,
  input  logic            InstrValidF,
  output logic            InstrValidD,
  output logic            InstrValidE,
  output logic            InstrValidM,
  output logic            InstrValidW,
  output logic            InstrRetiredW,
  input  logic [2:0]      CntInhibit,
  input  logic            CntWriteEn,
  input  logic [1:0]      CntSel,
  input  logic [CNTW-1:0] CntWriteData,
  output logic [CNTW-1:0] CycleCnt,
  output logic [CNTW-1:0] RetiredCnt,
  output logic [CNTW-1:0] BubbleCnt
);

  logic cycleWrite;
  logic retiredWrite;
  logic bubbleWrite;
  logic bubbleEvent;

  // Valid chain: each stage takes the previous stage's valid when not
  // stalled, holds when stalled (so a stalled bubble stays a bubble) and is
  // emptied by its flush regardless of the stall.
  openhw_flopenrc #(.WIDTH(1)) u_validD (
    .clk(clk), .reset(reset), .clear(FlushD), .en(!StallD),
    .d(InstrValidF), .q(InstrValidD)
  );

  openhw_flopenrc #(.WIDTH(1)) u_validE (
    .clk(clk), .reset(reset), .clear(FlushE), .en(!StallE),
    .d(InstrValidD), .q(InstrValidE)
  );

  openhw_flopenrc #(.WIDTH(1)) u_validM (
    .clk(clk), .reset(reset), .clear(FlushM), .en(!StallM),
    .d(InstrValidE), .q(InstrValidM)
  );

  openhw_flopenrc #(.WIDTH(1)) u_validW (
    .clk(clk), .reset(reset), .clear(FlushW), .en(!StallW),
    .d(InstrValidM), .q(InstrValidW)
  );

  // Commit happens in the same cycle the W instruction is allowed to leave.
  assign InstrRetiredW = InstrValidW & ~StallW & ~FlushW;

  // A bubble is an empty W slot that is actually advancing.
  assign bubbleEvent = ~StallW & ~InstrValidW;

  // Decode the CSR write select; the reserved encoding hits no counter.
  always_comb begin
    cycleWrite   = 1'b0;
    retiredWrite = 1'b0;
    bubbleWrite  = 1'b0;
    if (CntWriteEn) begin
      case (cnt_sel_e'(CntSel))
        CNT_CYCLE:   cycleWrite   = 1'b1;
        CNT_RETIRED: retiredWrite = 1'b1;
        CNT_BUBBLE:  bubbleWrite  = 1'b1;
        default:     ;
      endcase
    end
  end

  openhw_perfcnt #(.CNTW(CNTW)) u_cycleCnt (
    .clk(clk), .reset(reset), .Inhibit(CntInhibit[0]), .IncEn(1'b1),
    .WriteEn(cycleWrite), .WriteData(CntWriteData), .Count(CycleCnt)
  );

  openhw_perfcnt #(.CNTW(CNTW)) u_retiredCnt (
    .clk(clk), .reset(reset), .Inhibit(CntInhibit[1]), .IncEn(InstrRetiredW),
    .WriteEn(retiredWrite), .WriteData(CntWriteData), .Count(RetiredCnt)
  );

  openhw_perfcnt #(.CNTW(CNTW)) u_bubbleCnt (
    .clk(clk), .reset(reset), .Inhibit(CntInhibit[2]), .IncEn(bubbleEvent),
    .WriteEn(bubbleWrite), .WriteData(CntWriteData), .Count(BubbleCnt)
  );

endmodule
